booth_mult_seq: RTL and testbench

Parametrised sequential radix-2 Booth multiplier; successor to the fixed 13-bit datapath multiplier. Adds configurable operand width, a per-operation signed/unsigned mode, a START/BUSY/VALID/ACK handshake with result hold, and an add/sub activity counter for error-correction monitoring. It sits between the operand source and the result consumer in the multiplier datapath and performs one Booth step per clock.

---
 rtl/booth_mult_seq.sv | 130 +++++++++++++
 tb/tb_booth_mult_seq.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier, one step per clock.
// START/BUSY/VALID/ACK handshake with result hold and add/sub step counter.
module booth_mult_seq #(
  parameter int WIDTH = 13,
  parameter int CNT_W = $clog2(WIDTH + 2)
) (
  input  logic                 CLK,
  input  logic                 CLR,
  input  logic                 START,
  input  logic                 SIGNED_MODE,
  input  logic [WIDTH-1:0]     MULTIPLIER,
  input  logic [WIDTH-1:0]     MULTIPLICAND,
  output logic                 BUSY,
  output logic                 VALID,
  input  logic                 ACK,
  output logic [2*WIDTH-1:0]   RESULT,
  output logic [CNT_W-1:0]     OP_COUNT
);

  localparam int XW = WIDTH + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HOLD
  } state_t;

  state_t             state_q;
  logic [XW-1:0]      a_q, m_q, q_q;
  logic               qm1_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               busy_q, valid_q;
  logic [2*WIDTH-1:0] result_q;
  logic [CNT_W-1:0]   opcnt_q;

  logic [XW-1:0]      sum_d, a_d, q_d;
  logic               qm1_d;
  logic               op_step;
  logic [2*WIDTH-1:0] result_d;
  logic               accept;
  logic [XW-1:0]      mplier_x, mcand_x;

  always_comb begin
    sum_d   = a_q;
    op_step = 1'b0;
    unique case ({q_q[0], qm1_q})
      2'b10: begin
        sum_d   = a_q - m_q;
        op_step = 1'b1;
      end
      2'b01: begin
        sum_d   = a_q + m_q;
        op_step = 1'b1;
      end
      default: sum_d = a_q;
    endcase
    // Arithmetic right shift of {A', Q, Q-1}
    a_d      = {sum_d[XW-1], sum_d[XW-1:1]};
    q_d      = {sum_d[0], q_q[XW-1:1]};
    qm1_d    = q_q[0];
    result_d = {a_d[WIDTH-2:0], q_d};
  end

  always_comb begin
    mplier_x = {SIGNED_MODE & MULTIPLIER[WIDTH-1], MULTIPLIER};
    mcand_x  = {SIGNED_MODE & MULTIPLICAND[WIDTH-1], MULTIPLICAND};
    accept   = START & ((state_q == IDLE) |
               ((state_q == HOLD) & ACK));
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      state_q  <= IDLE;
      a_q      <= '0;
      m_q      <= '0;
      q_q      <= '0;
      qm1_q    <= 1'b0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      result_q <= '0;
      opcnt_q  <= '0;
    end else if (accept) begin
      state_q <= RUN;
      a_q     <= '0;
      m_q     <= mcand_x;
      q_q     <= mplier_x;
      qm1_q   <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
      valid_q <= 1'b0;
      opcnt_q <= '0;
    end else begin
      case (state_q)
        RUN: begin
          a_q   <= a_d;
          q_q   <= q_d;
          qm1_q <= qm1_d;
          cnt_q <= cnt_q + CNT_W'(1);
          if (op_step) opcnt_q <= opcnt_q + CNT_W'(1);
          if (cnt_q == LAST) begin
            state_q  <= HOLD;
            busy_q   <= 1'b0;
            valid_q  <= 1'b1;
            result_q <= result_d;
          end
        end
        HOLD: begin
          if (ACK) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
          end
        end
        IDLE: state_q <= IDLE;
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign BUSY     = busy_q;
  assign VALID    = valid_q;
  assign RESULT   = result_q;
  assign OP_COUNT = opcnt_q;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Directed self-checking bench for booth_mult_seq (WIDTH=13).
// Each scenario task drives stimulus and checks its own expectations.
module tb_booth_mult_seq;

  logic        CLK = 1'b0;
  logic        CLR, START, SIGNED_MODE, ACK;
  logic [12:0] MULTIPLIER, MULTIPLICAND;
  logic        BUSY, VALID;
  logic [25:0] RESULT;
  logic [3:0]  OP_COUNT;

  int checks = 0;
  int errors = 0;

  booth_mult_seq #(.WIDTH(13)) dut (
    .CLK(CLK),
    .CLR(CLR),
    .START(START),
    .SIGNED_MODE(SIGNED_MODE),
    .MULTIPLIER(MULTIPLIER),
    .MULTIPLICAND(MULTIPLICAND),
    .BUSY(BUSY),
    .VALID(VALID),
    .ACK(ACK),
    .RESULT(RESULT),
    .OP_COUNT(OP_COUNT)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_accept(input logic sm, input logic [12:0] mp,
                           input logic [12:0] mc);
    SIGNED_MODE  = sm;
    MULTIPLIER   = mp;
    MULTIPLICAND = mc;
    START        = 1'b1;
    tick();
    START        = 1'b0;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (VALID !== 1'b1 && cyc < 40) begin
      tick();
      cyc++;
    end
  endtask

  task automatic release_result();
    ACK = 1'b1;
    tick();
    ACK = 1'b0;
  endtask

  task automatic test_reset();
    CLR = 1'b1; START = 1'b1; ACK = 1'b0; SIGNED_MODE = 1'b1;
    MULTIPLIER = 13'd5; MULTIPLICAND = 13'd7;
    tick();
    tick();
    checks++;
    if (BUSY !== 1'b0) begin
      errors++; $display("FAIL reset_busy: got %b expected 0", BUSY);
    end
    checks++;
    if (VALID !== 1'b0) begin
      errors++; $display("FAIL reset_valid: got %b expected 0", VALID);
    end
    checks++;
    if (RESULT !== 26'h0) begin
      errors++; $display("FAIL reset_result: got %h expected 0", RESULT);
    end
    checks++;
    if (OP_COUNT !== 4'd0) begin
      errors++; $display("FAIL reset_opcount: got %0d expected 0", OP_COUNT);
    end
    START = 1'b0;
    CLR   = 1'b0;
    tick();
    checks++;
    if (BUSY !== 1'b0) begin
      errors++; $display("FAIL reset_no_accept: busy %b expected 0", BUSY);
    end
  endtask

  task automatic test_basic();
    int cyc;
    do_accept(1'b1, 13'd5, 13'h1FFD);
    checks++;
    if (BUSY !== 1'b1 || VALID !== 1'b0) begin
      errors++;
      $display("FAIL basic_busy: busy %b valid %b expected 1 0", BUSY, VALID);
    end
    // START and operand changes during RUN must not matter
    START = 1'b1; MULTIPLIER = 13'd0; MULTIPLICAND = 13'd0; SIGNED_MODE = 1'b0;
    ACK = 1'b1;
    wait_valid(cyc);
    START = 1'b0; ACK = 1'b0;
    checks++;
    if (cyc !== 14) begin
      errors++; $display("FAIL basic_latency: got %0d expected 14", cyc);
    end
    checks++;
    if (RESULT !== 26'h3FFFFF1) begin
      errors++; $display("FAIL basic_result: got %h expected 3fffff1", RESULT);
    end
    checks++;
    if (OP_COUNT !== 4'd4) begin
      errors++; $display("FAIL basic_opcount: got %0d expected 4", OP_COUNT);
    end
    checks++;
    if (BUSY !== 1'b0) begin
      errors++; $display("FAIL basic_busy_done: got %b expected 0", BUSY);
    end
    release_result();
    checks++;
    if (VALID !== 1'b0) begin
      errors++; $display("FAIL basic_ack: valid %b expected 0", VALID);
    end
  endtask

  task automatic test_corners();
    int cyc;
    do_accept(1'b1, 13'h1000, 13'h1000);
    wait_valid(cyc);
    checks++;
    if (cyc !== 14 || RESULT !== 26'h1000000) begin
      errors++;
      $display("FAIL signed_min: got %h lat %0d expected 1000000 lat 14", RESULT, cyc);
    end
    release_result();
    do_accept(1'b0, 13'h1FFF, 13'h1FFF);
    wait_valid(cyc);
    checks++;
    if (RESULT !== 26'h3FFC001) begin
      errors++; $display("FAIL unsigned_max: got %h expected 3ffc001", RESULT);
    end
    checks++;
    if (OP_COUNT !== 4'd2) begin
      errors++; $display("FAIL unsigned_max_opcount: got %0d expected 2", OP_COUNT);
    end
    release_result();
    do_accept(1'b0, 13'h0000, 13'h1234);
    wait_valid(cyc);
    checks++;
    if (RESULT !== 26'h0 || OP_COUNT !== 4'd0) begin
      errors++;
      $display("FAIL zero_mult: got %h/%0d expected 0/0", RESULT, OP_COUNT);
    end
    release_result();
  endtask

  task automatic test_hold();
    int cyc;
    do_accept(1'b0, 13'd100, 13'd200);
    wait_valid(cyc);
    checks++;
    if (cyc !== 14) begin
      errors++; $display("FAIL hold_latency: got %0d expected 14", cyc);
    end
    for (int i = 0; i < 20; i++) begin
      START = i[0];
      MULTIPLIER = 13'(i * 37);
      MULTIPLICAND = 13'(i * 91 + 3);
      SIGNED_MODE = i[1];
      tick();
      checks++;
      if (VALID !== 1'b1 || BUSY !== 1'b0 || RESULT !== 26'd20000 ||
          OP_COUNT !== 4'd4) begin
        errors++;
        $display("FAIL hold_stable[%0d]: v%b b%b %h/%0d expected v1 b0 4e20/4",
                 i, VALID, BUSY, RESULT, OP_COUNT);
      end
    end
    START = 1'b0;
    release_result();
    checks++;
    if (VALID !== 1'b0 || BUSY !== 1'b0) begin
      errors++; $display("FAIL hold_release: v%b b%b expected 0 0", VALID, BUSY);
    end
    ACK = 1'b1;
    tick();
    ACK = 1'b0;
    checks++;
    if (VALID !== 1'b0 || BUSY !== 1'b0 || RESULT !== 26'd20000) begin
      errors++;
      $display("FAIL idle_ack: v%b b%b %h expected 0 0 4e20", VALID, BUSY, RESULT);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    do_accept(1'b1, 13'd5, 13'h1FFD);
    wait_valid(cyc);
    SIGNED_MODE = 1'b0; MULTIPLIER = 13'd7; MULTIPLICAND = 13'd9;
    ACK = 1'b1; START = 1'b1;
    tick();
    ACK = 1'b0; START = 1'b0;
    checks++;
    if (BUSY !== 1'b1 || VALID !== 1'b0) begin
      errors++; $display("FAIL b2b_accept: b%b v%b expected 1 0", BUSY, VALID);
    end
    checks++;
    if (RESULT !== 26'h3FFFFF1) begin
      errors++; $display("FAIL b2b_result_hold: got %h expected 3fffff1", RESULT);
    end
    wait_valid(cyc);
    checks++;
    if (cyc !== 14 || RESULT !== 26'd63) begin
      errors++; $display("FAIL b2b_result: got %0d lat %0d expected 63 lat 14", RESULT, cyc);
    end
    checks++;
    if (OP_COUNT !== 4'd2) begin
      errors++; $display("FAIL b2b_opcount: got %0d expected 2", OP_COUNT);
    end
    release_result();
  endtask

  task automatic test_clr_abort();
    int cyc;
    do_accept(1'b1, 13'h1F9C, 13'd77);
    repeat (5) tick();
    CLR = 1'b1;
    tick();
    CLR = 1'b0;
    checks++;
    if (BUSY !== 1'b0 || VALID !== 1'b0 || RESULT !== 26'h0 ||
        OP_COUNT !== 4'd0) begin
      errors++;
      $display("FAIL clr_abort: b%b v%b %h/%0d expected 0 0 0/0",
               BUSY, VALID, RESULT, OP_COUNT);
    end
    tick();
    checks++;
    if (BUSY !== 1'b0 || VALID !== 1'b0) begin
      errors++; $display("FAIL clr_idle: b%b v%b expected 0 0", BUSY, VALID);
    end
    do_accept(1'b0, 13'd2, 13'd3);
    wait_valid(cyc);
    checks++;
    if (cyc !== 14 || RESULT !== 26'd6 || OP_COUNT !== 4'd2) begin
      errors++;
      $display("FAIL clr_next: got %0d/%0d lat %0d expected 6/2 lat 14",
               RESULT, OP_COUNT, cyc);
    end
    release_result();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_corners();
    test_hold();
    test_back_to_back();
    test_clr_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
